main_div_108ns_52s_56_seq: RTL and testbench
============================================

// Module: main_div_108ns_52s_56_seq
// PURPOSE
//  Iterative restoring divider, the inverse of the pipelined 56ns x 52s -> 108 multiplier.
//  Computes unsigned din0 / signed din1 -> signed quotient + unsigned remainder, one bit per cycle.
//  Used in the locobot kernels to undo fixed-point products (rescale / normalise).
//  Start/done handshake. ce freezes all state.
// PARAMETERS
//  ID          1    instance tag, no functional effect
//  din0_WIDTH  108  dividend width (unsigned)
//  din1_WIDTH  52   divisor width (two's complement)
//  dout_WIDTH  56   quotient width (two's complement)
// PORTS
//  clk    in   1           clock, rising edge
//  reset  in   1           synchronous reset, active-low (asserted when 0)
//  ce     in   1           clock enable; 0 = every register holds
//  start  in   1           request; sampled only in IDLE/DONE with ce=1
//  din0   in   din0_WIDTH  dividend, captured on accepted start
//  din1   in   din1_WIDTH  divisor, captured on accepted start
//  busy   out  1           1 while iterating
//  done   out  1           1 while results valid; held until next accepted start
//  dout   out  dout_WIDTH  quotient
//  rem    out  din1_WIDTH  remainder, always >= 0, < |din1|
//  div0   out  1           divisor was zero
//  ovf    out  1           true quotient outside signed dout_WIDTH range
// BEHAVIOUR
//  Reset (reset=0 at edge, regardless of ce): state=IDLE; busy/done/dout/rem/div0/ovf = 0.
//  Reset mid-operation aborts; no result produced. Takes priority over start.
//  FSM: IDLE -start-> BUSY -count==0-> DONE -start-> BUSY. Transitions only on ce=1 edges.
//  Accept edge: latch din0, |din1| (din1_WIDTH-bit unsigned; -2^51 -> 2^51), sign(din1);
//   clear partial remainder; counter=din0_WIDTH; busy=1, done=0.
//  BUSY, per ce edge: shift next dividend MSB into partial remainder (din1_WIDTH+1 bits);
//   if >= |din1| subtract, quotient bit=1, else 0; counter--.
//  Final edge: quotient negated if din1<0; registered to dout/rem/flags; busy=0, done=1.
//  Latency fixed: done high after din0_WIDTH+1 ce-edges from accept edge (109 default),
//   including div0 case. ce=0 cycles extend it 1:1.
//  start while BUSY: ignored. start in DONE: accepted, done drops next edge.
//  Rounding: truncate toward zero; remainder non-negative (dividend unsigned).
//  Overflow: |q| >= 2^(dout_WIDTH-1) for q>0, or > 2^(dout_WIDTH-1) for q<0 -> ovf=1.
//   q = -2^(dout_WIDTH-1) exactly is not overflow.
//  Default (no macro): dout = low dout_WIDTH bits of two's-complement quotient (wrap).
//  din1==0: div0=1, ovf=0, dout=all-ones, rem=din0[din1_WIDTH-1:0].
//  dout/rem/flags stable from done rise until the next accepted start.
// CONFIGURATION
//  MAIN_DIV_SAT_EN defined: on ovf=1, dout clamps to 2^(dout_WIDTH-1)-1 (q>0)
//   or -2^(dout_WIDTH-1) (q<0); div0 gives dout = 2^(dout_WIDTH-1)-1. ovf/div0 flags unchanged.
//  Undefined: wrap behaviour above. Latency identical either way.
// TESTING
//  100 / 7, ce=1 -> done on 109th edge after accept; dout=14, rem=2, ovf=0, div0=0.
//  100 / -7 -> dout=56'hFF_FFFF_FFFF_FFF2 (-14), rem=2.
//  5 / 0 -> div0=1, dout=56'hFF_FFFF_FFFF_FFFF (SAT_EN: 56'h7F_FFFF_FFFF_FFFF), rem=5.
//  2^60 / 1 -> ovf=1; dout=0 wrap, 56'h7F_FFFF_FFFF_FFFF with MAIN_DIV_SAT_EN; 2^55 / -1 -> ovf=0, dout=56'h80_0000_0000_0000.
//  100 / 7 with ce=0 for 10 cycles mid-BUSY, start pulsed during BUSY -> done at edge 119, same result, second start ignored.
//  reset=0 at BUSY edge 50 -> busy=done=dout=rem=0 next edge; fresh 9 / 3 -> dout=3, rem=0 after 109 edges.

Source files
------------

// File: rtl/main_div_108ns_52s_56_seq.sv
`default_nettype none
// ============================================================================
// Module   : main_div_108ns_52s_56_seq
// Purpose  : Iterative restoring divider, unsigned din0 / signed din1, one
//            quotient bit per ce-qualified clock. Saturating output: MAIN_DIV_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module main_div_108ns_52s_56_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 108,
    parameter int din1_WIDTH = 52,
    parameter int dout_WIDTH = 56
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div0,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(din0_WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(din0_WIDTH);
    localparam logic [din0_WIDTH-1:0] C_Q_LIM =
        {{(din0_WIDTH-1){1'b0}}, 1'b1} << (dout_WIDTH - 1);
    localparam logic [dout_WIDTH-1:0] C_DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] C_DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    // ID is an instance tag only; this branch never elaborates for legal values.
    if (ID < 0) begin : g_id_tag_invalid
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [din0_WIDTH-1:0]   quo_q, quo_d;
    logic [din1_WIDTH-1:0]   prem_q, prem_d;
    logic [din1_WIDTH-1:0]   dvsr_q, dvsr_d;
    logic                    neg_q, neg_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [dout_WIDTH-1:0]   dout_q, dout_d;
    logic [din1_WIDTH-1:0]   rem_q, rem_d;
    logic                    div0_q, div0_d;
    logic                    ovf_q, ovf_d;

    // Dividend bits leave quo_q at the top while quotient bits enter at the bottom.
    logic [din1_WIDTH:0]     w_prem_shift;
    logic                    w_ge;
    logic [din1_WIDTH-1:0]   w_prem_sub;
    logic                    w_div0;
    logic                    w_ovf;
    logic [dout_WIDTH-1:0]   w_dout_wrap;
    logic [dout_WIDTH-1:0]   w_dout_fin;

    assign w_prem_shift = {prem_q, quo_q[din0_WIDTH-1]};
    assign w_ge         = (w_prem_shift >= {1'b0, dvsr_q});
    // When w_ge holds the true difference is below the divisor, so modulo is exact.
    assign w_prem_sub   = w_prem_shift[din1_WIDTH-1:0] - dvsr_q;

    assign w_div0      = (dvsr_q == '0);
    assign w_ovf       = !w_div0 && (neg_q ? (quo_q > C_Q_LIM) : (quo_q >= C_Q_LIM));
    assign w_dout_wrap = neg_q ? (dout_WIDTH'(0) - quo_q[dout_WIDTH-1:0])
                               : quo_q[dout_WIDTH-1:0];

    always_comb begin
        w_dout_fin = w_dout_wrap;
`ifdef MAIN_DIV_SAT_EN
        if (w_div0) begin
            w_dout_fin = C_DOUT_MAX;
        end else if (w_ovf) begin
            w_dout_fin = neg_q ? C_DOUT_MIN : C_DOUT_MAX;
        end
`else
        if (w_div0) begin
            w_dout_fin = '1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        prem_d  = prem_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    quo_d   = din0;
                    neg_d   = din1[din1_WIDTH-1];
                    dvsr_d  = din1[din1_WIDTH-1] ? (din1_WIDTH'(0) - din1) : din1;
                    prem_d  = '0;
                    cnt_d   = C_CNT_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    prem_d = w_ge ? w_prem_sub : w_prem_shift[din1_WIDTH-1:0];
                    quo_d  = {quo_q[din0_WIDTH-2:0], w_ge};
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    dout_d  = w_dout_fin;
                    rem_d   = prem_q;
                    div0_d  = w_div0;
                    ovf_d   = w_ovf;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            prem_q  <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            prem_q  <= prem_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign rem  = rem_q;
    assign div0 = div0_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_main_div_108ns_52s_56_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_div_108ns_52s_56_seq
// Purpose  : Directed vector bench for the iterative divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_main_div_108ns_52s_56_seq;

    localparam int AW = 108;
    localparam int BW = 52;
    localparam int QW = 56;
    localparam int NV = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ce = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] din0 = '0;
    logic [BW-1:0] din1 = '0;
    logic          busy, done, div0, ovf;
    logic [QW-1:0] dout;
    logic [BW-1:0] rem;

    int n_pass = 0;
    int n_total = 0;

    main_div_108ns_52s_56_seq #(
        .ID(1), .din0_WIDTH(AW), .din1_WIDTH(BW), .dout_WIDTH(QW)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1),
        .busy(busy), .done(done), .dout(dout), .rem(rem),
        .div0(div0), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [QW-1:0] q;
        logic [BW-1:0] r;
        logic          dz;
        logic          ov;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // Drive one request at a falling edge; lat = edges from accept to done.
    task automatic run(input logic [AW-1:0] a, input logic [BW-1:0] b, output int lat);
        @(negedge clk);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_done_low", 128'(done), 128'(0));
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [QW-1:0] held;

        vecs[0]  = '{108'd100, 52'd7, 56'd14, 52'd2, 1'b0, 1'b0};
        vecs[1]  = '{108'd100, 52'hF_FFFF_FFFF_FFF9, 56'hFF_FFFF_FFFF_FFF2, 52'd2, 1'b0, 1'b0};
`ifdef MAIN_DIV_SAT_EN
        vecs[2]  = '{108'd5, 52'd0, 56'h7F_FFFF_FFFF_FFFF, 52'd5, 1'b1, 1'b0};
        vecs[3]  = '{108'h1000_0000_0000_0000, 52'd1, 56'h7F_FFFF_FFFF_FFFF, 52'd0, 1'b0, 1'b1};
        vecs[5]  = '{108'h80_0000_0000_0000, 52'd1, 56'h7F_FFFF_FFFF_FFFF, 52'd0, 1'b0, 1'b1};
        vecs[6]  = '{108'h80_0000_0000_0001, 52'hF_FFFF_FFFF_FFFF, 56'h80_0000_0000_0000, 52'd0, 1'b0, 1'b1};
        vecs[12] = '{{AW{1'b1}}, 52'd1, 56'h7F_FFFF_FFFF_FFFF, 52'd0, 1'b0, 1'b1};
`else
        vecs[2]  = '{108'd5, 52'd0, 56'hFF_FFFF_FFFF_FFFF, 52'd5, 1'b1, 1'b0};
        vecs[3]  = '{108'h1000_0000_0000_0000, 52'd1, 56'd0, 52'd0, 1'b0, 1'b1};
        vecs[5]  = '{108'h80_0000_0000_0000, 52'd1, 56'h80_0000_0000_0000, 52'd0, 1'b0, 1'b1};
        vecs[6]  = '{108'h80_0000_0000_0001, 52'hF_FFFF_FFFF_FFFF, 56'h7F_FFFF_FFFF_FFFF, 52'd0, 1'b0, 1'b1};
        vecs[12] = '{{AW{1'b1}}, 52'd1, 56'hFF_FFFF_FFFF_FFFF, 52'd0, 1'b0, 1'b1};
`endif
        vecs[4]  = '{108'h80_0000_0000_0000, 52'hF_FFFF_FFFF_FFFF, 56'h80_0000_0000_0000, 52'd0, 1'b0, 1'b0};
        vecs[7]  = '{108'd0, 52'hF_FFFF_FFFF_FFFD, 56'd0, 52'd0, 1'b0, 1'b0};
        vecs[8]  = '{108'd7, 52'd100, 56'd0, 52'd7, 1'b0, 1'b0};
        vecs[9]  = '{108'h18_0000_0000_0005, 52'h8_0000_0000_0000, 56'hFF_FFFF_FFFF_FFFD, 52'd5, 1'b0, 1'b0};
        vecs[10] = '{108'd999999, 52'd1000, 56'd999, 52'd999, 1'b0, 1'b0};
        vecs[11] = '{108'd12345678, 52'hF_FFFF_FFFF_CFC7, 56'hFF_FFFF_FFFF_FC18, 52'd678, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_rem",  128'(rem),  128'(0));
        check("rst_div0", 128'(div0), 128'(0));
        check("rst_ovf",  128'(ovf),  128'(0));
        @(negedge clk);
        reset = 1'b1;

        // Vector table, back to back (each start after the first lands in DONE)
        for (int i = 0; i < NV; i++) begin
            run(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 128'(lat),  128'(109));
            check($sformatf("v%0d_dout", i),    128'(dout), 128'(vecs[i].q));
            check($sformatf("v%0d_rem", i),     128'(rem),  128'(vecs[i].r));
            check($sformatf("v%0d_div0", i),    128'(div0), 128'(vecs[i].dz));
            check($sformatf("v%0d_ovf", i),     128'(ovf),  128'(vecs[i].ov));
            check($sformatf("v%0d_busy", i),    128'(busy), 128'(0));
        end

        // Result holds while idle in DONE; start with ce=0 is not accepted
        held = dout;
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", 128'(done), 128'(1));
        check("hold_dout", 128'(dout), 128'(held));
        ce = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ce = 1'b1;
        check("ce0_start_done", 128'(done), 128'(1));
        check("ce0_start_busy", 128'(busy), 128'(0));

        // ce stall of 10 edges plus an ignored start while busy
        @(negedge clk);
        din0 = 108'd100;
        din1 = 52'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            if (lat == 20) ce = 1'b0;
            if (lat == 25) check("stall_busy", 128'(busy), 128'(1));
            if (lat == 30) ce = 1'b1;
            if (lat == 40) begin
                start = 1'b1;
                din0 = 108'd9;
                din1 = 52'd3;
            end
            if (lat == 41) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_latency", 128'(lat),  128'(119));
        check("stall_dout",    128'(dout), 128'(14));
        check("stall_rem",     128'(rem),  128'(2));
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_done", 128'(done), 128'(1));

        // Reset in the middle of an operation
        @(negedge clk);
        din0 = 108'd100;
        din1 = 52'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_dout", 128'(dout), 128'(0));
        check("midrst_rem",  128'(rem),  128'(0));
        @(negedge clk);
        reset = 1'b1;
        run(108'd9, 52'd3, lat);
        check("post_rst_latency", 128'(lat),  128'(109));
        check("post_rst_dout",    128'(dout), 128'(3));
        check("post_rst_rem",     128'(rem),  128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
